dct_coef_engine: RTL and testbench
==================================

// Module: dct_coef_engine
// PURPOSE
//  Runtime-selectable 8x8 2-D DCT coefficient engine; replaces one fixed-(k1,k2) cosine table per coefficient.
//  Buffers one 8x8 block, then on each request computes F(k1,k2) = sum x[n1][n2]*C(k1,n1)*C(k2,n2) with one MAC/cycle.
//  Sits between the block tiler (sample stream in) and the coefficient quantiser (result stream out).
//  Serves any number of requests per buffered block.
// PARAMETERS
//  DATA_W   9   signed sample width (two's complement)
//  COS_FRAC 8   fraction bits of 1-D cosine LUT; 2-D term is Q(2*COS_FRAC)
//  OUT_W    24  signed result width; saturating
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  rst_n     in   1       synchronous reset, active low
//  in_valid  in   1       sample valid
//  in_ready  out  1       engine accepts sample (state LOAD)
//  in_data   in   DATA_W  sample, row-major order: index = 8*n1+n2
//  req_valid in   1       coefficient request valid
//  req_ready out  1       request accepted (state IDLE)
//  req_k1    in   3       row frequency 0..7
//  req_k2    in   3       column frequency 0..7
//  req_last  in   1       last request for this block; buffer released after its result
//  out_valid out  1       result valid, held until out_ready
//  out_ready in   1       consumer accepts result
//  out_data  out  OUT_W   F(k1,k2), scaled by 2^COS_FRAC
//  out_sat   out  1       out_data was clipped
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=LOAD, counters=0, out_valid=0, out_data=0, out_sat=0; in_ready, req_ready forced 0 while rst_n=0.
//  Reset mid-operation aborts everything; partial block discarded, reload from sample 0.
//  FSM: LOAD -> IDLE -> CALC -> DONE -> IDLE | LOAD.
//   LOAD: in_ready=1; each in_valid&in_ready writes buffer[cnt], cnt++; handshake at cnt=63 -> IDLE.
//   IDLE: req_ready=1; req_valid&req_ready latches k1,k2,last, clears acc -> CALC. Requests ignored in other states.
//   CALC: idx 0..63, one term/cycle; 2-stage pipe (stage1: LUT terms+sample read, stage2: multiply-accumulate).
//   DONE: out_valid=1, out_data/out_sat stable until out_valid&out_ready; then -> LOAD if last else IDLE.
//  Latency: out_valid rises exactly 67 cycles after the request handshake cycle (out_ready ignored until then).
//  1-D LUT c[m], m=0..31: c[m]=round(2^COS_FRAC*cos(m*pi/16)) for m=0..8, rest by symmetry
//   c[16-m]=-c[m], c[32-m]=c[m] (exact odd symmetry, so non-DC sums of constants cancel to 0).
//  C(k,n)=c[((2n+1)*k) mod 32]; term=C(k1,n1)*C(k2,n2), signed 2*COS_FRAC+2 bits.
//  Accumulator: full precision, DATA_W+2*COS_FRAC+8 bits signed, no intermediate truncation.
//  Result: r=(acc+2^(COS_FRAC-1))>>>COS_FRAC (round half up, arithmetic shift);
//   r>2^(OUT_W-1)-1 -> max, out_sat=1; r<-2^(OUT_W-1) -> min, out_sat=1; else out_sat=0.
//  in_valid outside LOAD ignored (no write). out_ready outside DONE ignored.
//  Back-to-back: request may handshake the cycle after result handshake (IDLE entered that cycle).
//  Buffer contents unchanged from LOAD exit until next LOAD entry.
// TESTING (COS_FRAC=8, DATA_W=9, OUT_W=24)
//  All 64 samples=1, req (0,0) -> out_data=16384, out_sat=0, out_valid 67 cycles after req handshake.
//  Same block, req (1,0),(3,5),(7,7) -> each out_data=0; req (0,0) again -> 16384 (multi-request reuse).
//  x[0][0]=100 else 0, req (1,1) -> out_data=24610 (c[1]=251; 251*251*100=6300100 -> round/256).
//  All samples=-256, req (0,0) with OUT_W=16 -> out_data=-32768, out_sat=1.
//  out_ready low 20 cycles in DONE -> out_valid/out_data held; req_valid pulses during CALC/DONE ignored.
//  rst_n low 1 cycle at LOAD cnt=40 and again mid-CALC -> out_valid=0, in_ready=1 next cycle, full 64-sample reload required.

Source files
------------

// File: rtl/dct_coef_engine.sv
// 8x8 2-D DCT coefficient engine: buffers one block of samples, then serves
// F(k1,k2) requests with one multiply-accumulate per cycle.
module dct_coef_engine #(
    parameter int DATA_W   = 9,
    parameter int COS_FRAC = 8,
    parameter int OUT_W    = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_k1,
    input  logic [2:0]               req_k2,
    input  logic                     req_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_sat
);
    localparam int CW     = COS_FRAC + 2;
    localparam int TERM_W = 2*COS_FRAC + 2;
    localparam int PROD_W = DATA_W + TERM_W;
    localparam int ACC_W  = DATA_W + 2*COS_FRAC + 8;
    localparam int STAGES = 2;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2**(COS_FRAC-1));
    localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {LOAD, IDLE, CALC, DONE} state_t;

    // First octant of cos(m*pi/16) in Q16, rounded down to COS_FRAC bits (COS_FRAC <= 15).
    function automatic logic signed [CW-1:0] cos_base(input logic [3:0] m);
        int q;
        case (m)
            4'd0:    q = 65536;
            4'd1:    q = 64277;
            4'd2:    q = 60547;
            4'd3:    q = 54491;
            4'd4:    q = 46341;
            4'd5:    q = 36410;
            4'd6:    q = 25080;
            4'd7:    q = 12785;
            default: q = 0;
        endcase
        return CW'((q + (1 << (15 - COS_FRAC))) >>> (16 - COS_FRAC));
    endfunction

    function automatic logic signed [CW-1:0] cos_lut(input logic [4:0] m);
        logic [4:0] t;
        if (m <= 5'd8) begin
            t = m;
            return cos_base(t[3:0]);
        end else if (m <= 5'd16) begin
            t = 5'd16 - m;
            return -cos_base(t[3:0]);
        end else if (m <= 5'd23) begin
            t = m - 5'd16;
            return -cos_base(t[3:0]);
        end else begin
            t = 5'd0 - m;
            return cos_base(t[3:0]);
        end
    endfunction

    // 5-bit product gives the mod-32 wrap of (2n+1)*k for free.
    function automatic logic signed [CW-1:0] coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0] p;
        p = 5'({n, 1'b1}) * 5'(k);
        return cos_lut(p);
    endfunction

    state_t                     state;
    logic [5:0]                 cnt;
    logic [6:0]                 idx;
    logic [2:0]                 k1, k2;
    logic                       last_q;
    logic signed [DATA_W-1:0]   mem [64];
    logic                       s1_vld;
    logic signed [TERM_W-1:0]   s1_term;
    logic signed [DATA_W-1:0]   s1_smp;
    logic [STAGES:0]            vld_pipe;
    logic signed [ACC_W-1:0]    acc, r_q, rnd;
    logic signed [TERM_W-1:0]   ca, cb;
    logic signed [PROD_W-1:0]   prod;
    logic signed [OUT_W-1:0]    sat_d;
    logic                       sat_f;
    logic                       issue;

    assign in_ready  = rst_n && (state == LOAD);
    assign req_ready = rst_n && (state == IDLE);
    assign issue     = (state == CALC) && !idx[6];

    always_comb begin
        ca   = TERM_W'(coef(k1, idx[5:3]));
        cb   = TERM_W'(coef(k2, idx[2:0]));
        prod = PROD_W'(s1_smp) * PROD_W'(s1_term);
        rnd  = (acc + HALF) >>> COS_FRAC;
        sat_f = 1'b1;
        if (r_q > OMAX)      sat_d = OMAX[OUT_W-1:0];
        else if (r_q < OMIN) sat_d = OMIN[OUT_W-1:0];
        else begin
            sat_d = r_q[OUT_W-1:0];
            sat_f = 1'b0;
        end
    end

    // Sample buffer is not reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (rst_n && state == LOAD && in_valid)
            mem[cnt] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= '0;
            idx       <= '0;
            k1        <= '0;
            k2        <= '0;
            last_q    <= 1'b0;
            s1_vld    <= 1'b0;
            s1_term   <= '0;
            s1_smp    <= '0;
            vld_pipe  <= '0;
            acc       <= '0;
            r_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            // vld_pipe tracks the final term: [0] in stage1, [1] accumulated, [2] rounded.
            s1_vld   <= issue;
            vld_pipe <= {vld_pipe[STAGES-1:0], issue && (idx[5:0] == 6'd63)};
            if (issue) begin
                s1_term <= ca * cb;
                s1_smp  <= mem[idx[5:0]];
                idx     <= idx + 7'd1;
            end
            if (s1_vld)      acc <= acc + ACC_W'(prod);
            if (vld_pipe[1]) r_q <= rnd;
            case (state)
                LOAD: if (in_valid) begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) state <= IDLE;
                end
                IDLE: if (req_valid) begin
                    k1     <= req_k1;
                    k2     <= req_k2;
                    last_q <= req_last;
                    acc    <= '0;
                    idx    <= '0;
                    state  <= CALC;
                end
                CALC: if (vld_pipe[2]) begin
                    out_valid <= 1'b1;
                    out_data  <= sat_d;
                    out_sat   <= sat_f;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= last_q ? LOAD : IDLE;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_dct_coef_engine.sv
// Bench for dct_coef_engine: two instances (OUT_W 24 and 16) share stimulus;
// expected results are queued at request handshake and compared at output.
module tb_dct_coef_engine;
    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, req_valid, req_last, out_ready;
    logic signed [8:0] in_data;
    logic [2:0] req_k1, req_k2;
    logic in_ready, req_ready, out_valid, out_sat;
    logic in_ready16, req_ready16, out_valid16, out_sat16;
    logic signed [23:0] out_data;
    logic signed [15:0] out_data16;

    dct_coef_engine #(.DATA_W(9), .COS_FRAC(8), .OUT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_k1(req_k1), .req_k2(req_k2),
        .req_last(req_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat));

    dct_coef_engine #(.DATA_W(9), .COS_FRAC(8), .OUT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data),
        .req_valid(req_valid), .req_ready(req_ready16), .req_k1(req_k1), .req_k2(req_k2),
        .req_last(req_last), .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_sat(out_sat16));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] k1;
        logic [2:0] k2;
        logic       last;
        longint     exp;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     blk [64];
    int     ctab [9] = '{256, 251, 237, 213, 181, 142, 98, 50, 0};
    longint exp_q [$];
    vec_t   vecs [5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cq(input int m);
        int mm = m % 32;
        if (mm <= 8)       return ctab[mm];
        else if (mm <= 16) return -ctab[16-mm];
        else if (mm <= 24) return -ctab[mm-16];
        else               return ctab[32-mm];
    endfunction

    function automatic longint model(input int k1, input int k2);
        longint a = 0;
        for (int n1 = 0; n1 < 8; n1++)
            for (int n2 = 0; n2 < 8; n2++)
                a += longint'(blk[8*n1+n2]) * cq((2*n1+1)*k1) * cq((2*n2+1)*k2);
        return (a + 128) >>> 8;
    endfunction

    function automatic longint satw(input longint r, input int w);
        longint mx = (longint'(1) <<< (w-1)) - 1;
        longint mn = -(longint'(1) <<< (w-1));
        return (r > mx) ? mx : (r < mn) ? mn : r;
    endfunction

    task automatic load_samples(input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 9'(blk[i]);
            t = 0;
            while (!in_ready && t < 100) begin tick(); t++; end
            if (t >= 100) begin
                chk("load_timeout", i, -1);
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_req(input logic [2:0] k1, input logic [2:0] k2, input logic last, input longint exp);
        int t = 0;
        req_valid = 1'b1; req_k1 = k1; req_k2 = k2; req_last = last;
        while (!req_ready && t < 100) begin tick(); t++; end
        if (t >= 100) chk("req_timeout", t, 0);
        tick();
        req_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    task automatic get_resp(input int hold, input bit pulse, input logic last);
        int n = 0;
        longint e, d0;
        bit stable = 1'b1;
        while (!out_valid && n < 300) begin
            req_valid = pulse && (n == 10 || n == 40);
            req_k1 = 3'd7; req_k2 = 3'd7; req_last = 1'b1;
            tick();
            n++;
        end
        chk("latency", n, 67);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'sh7fff_ffff;
        chk("out_data24", longint'(out_data), satw(e, 24));
        chk("out_sat24", longint'(out_sat), longint'(satw(e, 24) != e));
        chk("out_data16", longint'(out_data16), satw(e, 16));
        chk("out_sat16", longint'(out_sat16), longint'(satw(e, 16) != e));
        if (hold > 0) begin
            d0 = longint'(out_data);
            for (int i = 0; i < hold; i++) begin
                req_valid = pulse;
                tick();
                if (!out_valid || longint'(out_data) != d0) stable = 1'b0;
            end
            chk("hold_stable", longint'(stable), 1);
        end
        req_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", longint'(out_valid), 0);
        chk("next_req_ready", longint'(req_ready), longint'(!last));
        chk("next_in_ready", longint'(in_ready), longint'(last));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; req_valid = 1'b0;
        req_k1 = '0; req_k2 = '0; req_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_req_ready", longint'(req_ready), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_sat", longint'(out_sat), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", longint'(in_ready), 1);

        // Constant block: DC term and cancelling non-DC terms, buffer reused.
        vecs[0] = '{3'd0, 3'd0, 1'b0, 16384};
        vecs[1] = '{3'd1, 3'd0, 1'b0, 0};
        vecs[2] = '{3'd3, 3'd5, 1'b0, 0};
        vecs[3] = '{3'd7, 3'd7, 1'b0, 0};
        vecs[4] = '{3'd0, 3'd0, 1'b1, 16384};
        for (int i = 0; i < 64; i++) blk[i] = 1;
        load_samples(64);
        for (int i = 0; i < 5; i++) begin
            send_req(vecs[i].k1, vecs[i].k2, vecs[i].last, vecs[i].exp);
            get_resp(0, 1'b0, vecs[i].last);
        end

        // Impulse block with stalled consumer and stray requests during CALC/DONE.
        for (int i = 0; i < 64; i++) blk[i] = 0;
        blk[0] = 100;
        load_samples(64);
        send_req(3'd1, 3'd1, 1'b0, 24610);
        get_resp(20, 1'b1, 1'b0);
        in_valid = 1'b1; in_data = 9'sd77;
        tick(); tick(); tick();
        in_valid = 1'b0;
        send_req(3'd0, 3'd0, 1'b1, 25600);
        get_resp(0, 1'b0, 1'b1);

        // Most negative block: clips on the 16-bit instance only.
        for (int i = 0; i < 64; i++) blk[i] = -256;
        load_samples(64);
        send_req(3'd0, 3'd0, 1'b1, -4194304);
        get_resp(0, 1'b0, 1'b1);

        // Random block checked against the model.
        for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 511)) - 256;
        load_samples(64);
        send_req(3'd2, 3'd3, 1'b0, model(2, 3));
        get_resp(0, 1'b0, 1'b0);
        send_req(3'd5, 3'd1, 1'b0, model(5, 1));
        get_resp(3, 1'b0, 1'b0);
        send_req(3'd0, 3'd7, 1'b1, model(0, 7));
        get_resp(0, 1'b0, 1'b1);

        // Reset part-way through a load: the whole block must be resent.
        for (int i = 0; i < 64; i++) blk[i] = 255 - 7*i;
        load_samples(40);
        rst_n = 1'b0;
        tick();
        chk("mid_load_rst_in_ready", longint'(in_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("mid_load_post_in_ready", longint'(in_ready), 1);
        for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 511)) - 256;
        load_samples(64);
        send_req(3'd4, 3'd4, 1'b0, model(4, 4));
        get_resp(0, 1'b0, 1'b0);

        // Reset during CALC: nothing emerges and the engine waits for a new block.
        send_req(3'd6, 3'd2, 1'b0, model(6, 2));
        for (int i = 0; i < 30; i++) tick();
        rst_n = 1'b0;
        tick();
        chk("mid_calc_rst_out_valid", longint'(out_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("mid_calc_post_in_ready", longint'(in_ready), 1);
        chk("mid_calc_post_req_ready", longint'(req_ready), 0);
        void'(exp_q.pop_front());
        begin
            bit quiet = 1'b1;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (out_valid) quiet = 1'b0;
            end
            chk("mid_calc_no_output", longint'(quiet), 1);
        end
        load_samples(64);
        send_req(3'd1, 3'd0, 1'b1, model(1, 0));
        get_resp(0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
